// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential imem fetches buffered as {pc, instr} pairs for decode.
// Optional FETCH_ALIGN_CHECK_EN: flag misaligned redirect targets and force them word-aligned.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] ir_o,
  output logic              misalign_o
);

  localparam int unsigned       PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned       SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt, remain;
  logic [CNT_W-1:0]  outstanding, outstanding_nxt, drop_cnt, drop_cnt_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, resp_pc, resp_pc_nxt;
  logic [ADDR_W-1:0] target;
  logic              valid_nxt;
  entry_t            head_nxt, push_entry;
  logic              grant, resp, drop, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_nxt;

  assign target       = {pc_addr_i[ADDR_W-1:2], 2'b00};
  assign misalign_nxt = pc_load_i & (pc_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_o <= 1'b0;
    else       misalign_o <= misalign_nxt;
  end
`else
  assign target     = pc_addr_i;
  assign misalign_o = 1'b0;
`endif

  // Credit counts buffered entries plus everything still in flight, including stale ones.
  assign imem_req_o  = ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH))
                       & ~pc_load_i & ~rst_i;
  assign imem_addr_o = fetch_pc;

  always_comb begin
    grant         = imem_req_o & imem_gnt_i;
    resp          = imem_rvalid_i & (outstanding != '0);
    drop          = resp & (drop_cnt != '0);
    push          = resp & ~drop & ~pc_load_i;
    pop           = valid_o & ready_i & ~pc_load_i;
    push_entry.pc = resp_pc;
    push_entry.ir = imem_rdata_i;

    remain          = count - CNT_W'(pop);
    rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
    wr_ptr_nxt      = wr_ptr + PTR_W'(push);
    count_nxt       = remain + CNT_W'(push);
    outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(resp);
    drop_cnt_nxt    = drop_cnt - CNT_W'(drop);
    fetch_pc_nxt    = grant ? fetch_pc + STEP : fetch_pc;
    resp_pc_nxt     = push ? resp_pc + STEP : resp_pc;
    valid_nxt       = 1'b0;
    head_nxt.pc     = pc_o;
    head_nxt.ir     = ir_o;

    // Head register: next stored entry, else a response arriving into an empty queue.
    if (remain != '0) begin
      valid_nxt = 1'b1;
      head_nxt  = mem[rd_ptr_nxt];
    end else if (push) begin
      valid_nxt = 1'b1;
      head_nxt  = push_entry;
    end

    // Redirect overrides everything; in-flight responses become stale.
    if (pc_load_i) begin
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
      valid_nxt    = 1'b0;
      head_nxt.pc  = pc_o;
      head_nxt.ir  = ir_o;
      drop_cnt_nxt = outstanding - CNT_W'(resp);
      fetch_pc_nxt = target;
      resp_pc_nxt  = target;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      valid_o     <= 1'b0;
      pc_o        <= '0;
      ir_o        <= '0;
    end else begin
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      valid_o     <= valid_nxt;
      pc_o        <= head_nxt.pc;
      ir_o        <= head_nxt.ir;
    end
  end

  // Queue storage, no reset needed: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  a_rvalid_in_flight: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, alignment and PC wrap.
module tb_fetch_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] MASK   = 32'hFFFF_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] pc_addr = '0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              gnt = 1'b1;
  logic              rvalid = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic              valid;
  logic              ready = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              misalign;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int grant_cnt = 0;

  logic        pv [8];
  logic [31:0] pa [8];
  logic [31:0] got_pc [4];
  logic [31:0] got_ir [4];
  int          got_n;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pc_load_i(pc_load), .pc_addr_i(pc_addr),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .valid_o(valid), .ready_i(ready), .pc_o(pc), .ir_o(ir), .misalign_o(misalign)
  );

  // Fixed-latency imem: grants shift down a pipe, response driven mid-cycle.
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = imem_req & gnt & ~rst;
    pa[0] = imem_addr;
    if (imem_req && gnt && !rst) grant_cnt++;
    if (rst) for (int i = 0; i < 8; i++) pv[i] = 1'b0;
  end

  always @(negedge clk) begin
    rvalid = pv[lat-1];
    rdata  = pa[lat-1] ^ MASK;
  end

  task automatic do_reset(input int lat_v);
    rst = 1'b1;
    pc_load = 1'b0;
    lat = lat_v;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Gathers up to n entries consumed by decode (ready assumed high), bounded by budget cycles.
  task automatic collect(input int budget, input int n);
    got_n = 0;
    for (int i = 0; i < budget; i++) begin
      if (valid === 1'b1) begin
        got_pc[got_n] = pc;
        got_ir[got_n] = ir;
        got_n++;
      end
      @(negedge clk);
      if (got_n >= n) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || pc !== 32'h0 || ir !== 32'h0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b pc=%h ir=%h misalign=%b, required 0/0/0/0",
               valid, pc, ir, misalign);
    end
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: imem_req=%b, required 0", imem_req);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    do_reset(1);
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_latency: valid=%b in cycle 2, required 0", valid);
    end
    @(negedge clk);
    exp = 32'h0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (valid !== 1'b1 || pc !== exp || ir !== (exp ^ MASK)) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b pc=%h ir=%h, required 1 pc=%h ir=%h",
                 i, valid, pc, ir, exp, exp ^ MASK);
      end
      exp = exp + 32'd4;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int g0;
    do_reset(1);
    ready = 1'b0;
    g0 = grant_cnt;
    repeat (20) @(negedge clk);
    n_checks++;
    if (grant_cnt - g0 != DEPTH) begin
      n_fail++;
      $display("FAIL bp_grants: %0d grants, required %0d", grant_cnt - g0, DEPTH);
    end
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_req: imem_req=%b when full, required 0", imem_req);
    end
    ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * i) || ir !== (32'(4 * i) ^ MASK)) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: valid=%b pc=%h ir=%h, required 1 pc=%h",
                 i, valid, pc, ir, 32'(4 * i));
      end
      @(negedge clk);
    end
    collect(10, 1);
    n_checks++;
    if (got_n != 1 || got_pc[0] !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_resume: got %0d entries pc=%h, required 1 pc=00000010", got_n, got_pc[0]);
    end
  endtask

  task automatic test_redirect_inflight;
    do_reset(3);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_empty: valid=%b before first response, required 0", valid);
    end
    pc_load = 1'b1;
    pc_addr = 32'h100;
    @(negedge clk);
    pc_load = 1'b0;
    collect(30, 3);
    n_checks++;
    if (got_n != 3) begin
      n_fail++;
      $display("FAIL inflight_count: got %0d entries, required 3", got_n);
    end
    for (int k = 0; k < got_n; k++) begin
      n_checks++;
      if (got_pc[k] !== 32'(32'h100 + 4 * k) || got_ir[k] !== (32'(32'h100 + 4 * k) ^ MASK)) begin
        n_fail++;
        $display("FAIL inflight_pc[%0d]: pc=%h ir=%h, required pc=%h", k, got_pc[k], got_ir[k],
                 32'(32'h100 + 4 * k));
      end
    end
  endtask

  task automatic test_redirect_with_pop;
    do_reset(1);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || pc !== 32'hC) begin
      n_fail++;
      $display("FAIL pop_redirect_pre: valid=%b pc=%h, required 1 pc=0000000c", valid, pc);
    end
    pc_load = 1'b1;
    pc_addr = 32'h400;
    @(negedge clk);
    pc_load = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_redirect_flush: valid=%b pc=%h, required valid 0", valid, pc);
    end
    collect(20, 2);
    n_checks++;
    if (got_n != 2 || got_pc[0] !== 32'h400 || got_pc[1] !== 32'h404) begin
      n_fail++;
      $display("FAIL pop_redirect_target: n=%0d pc0=%h pc1=%h, required 2 00000400 00000404",
               got_n, got_pc[0], got_pc[1]);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    pc_load = 1'b1;
    pc_addr = 32'h200;
    @(negedge clk);
    pc_addr = 32'h300;
    @(negedge clk);
    pc_load = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_flush: valid=%b, required 0", valid);
    end
    collect(20, 2);
    n_checks++;
    if (got_n != 2 || got_pc[0] !== 32'h300 || got_pc[1] !== 32'h304 ||
        got_ir[0] !== (32'h300 ^ MASK)) begin
      n_fail++;
      $display("FAIL b2b_target: n=%0d pc0=%h pc1=%h ir0=%h, required 2 00000300 00000304 %h",
               got_n, got_pc[0], got_pc[1], got_ir[0], 32'h300 ^ MASK);
    end
  endtask

  task automatic test_align_wrap;
    logic [31:0] base;
    base = ALIGN ? 32'h100 : 32'h102;
    do_reset(1);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    pc_load = 1'b1;
    pc_addr = 32'h102;
    @(negedge clk);
    pc_load = 1'b0;
    n_checks++;
    if (misalign !== ALIGN) begin
      n_fail++;
      $display("FAIL misalign_pulse: misalign=%b, required %b", misalign, ALIGN);
    end
    @(negedge clk);
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: misalign=%b, required 0", misalign);
    end
    collect(20, 2);
    n_checks++;
    if (got_n != 2 || got_pc[0] !== base || got_pc[1] !== (base + 32'd4)) begin
      n_fail++;
      $display("FAIL misalign_target: n=%0d pc0=%h pc1=%h, required 2 %h %h",
               got_n, got_pc[0], got_pc[1], base, base + 32'd4);
    end
    pc_load = 1'b1;
    pc_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0;
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_no_pulse: misalign=%b, required 0", misalign);
    end
    collect(20, 2);
    n_checks++;
    if (got_n != 2 || got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc: n=%0d pc0=%h pc1=%h, required 2 fffffffc 00000000",
               got_n, got_pc[0], got_pc[1]);
    end
    n_checks++;
    if (got_ir[0] !== 32'h0000_FFFC || got_ir[1] !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL wrap_ir: ir0=%h ir1=%h, required 0000fffc ffff0000", got_ir[0], got_ir[1]);
    end
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 5000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_pop();
    test_back_to_back();
    test_align_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
